// File: rtl/fifo_wr_arbiter_pkg.sv
// fifo_arb_pkg: shared constants, index-width helper and arbiter state type
// for the fifo_wr_arbiter slice.
package fifo_arb_pkg;

   localparam int NREQ_DEF = 4;
   localparam int DW_DEF   = 24;
   localparam int AW_DEF   = 7;

   // Source-tag width; a single requester still gets one tag bit.
   function automatic int idw(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

   typedef enum logic {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } arb_state_e;

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// fifo_wr_arbiter_if: requester handshake + FIFO write/read side bundle.
// slave: arbiter side; master: producers/FIFO model side.
interface fifo_wr_arbiter_if
   import fifo_arb_pkg::*;
#(
   parameter int NREQ = NREQ_DEF,
   parameter int DW   = DW_DEF,
   parameter int AW   = AW_DEF
) ();

   localparam int IDW = idw(NREQ);

   logic [NREQ-1:0]    req_valid_i;
   logic [NREQ*DW-1:0] req_data_i;
   logic [NREQ-1:0]    req_last_i;
   logic [NREQ-1:0]    req_ready_o;
   logic               fifo_wr_o;
   logic [IDW+DW-1:0]  fifo_din_o;
   logic               fifo_full_i;
   logic               fifo_rd_i;
   logic               fifo_empty_i;
   logic [AW:0]        level_o;

   modport slave (
      input  req_valid_i, req_data_i, req_last_i,
      input  fifo_full_i, fifo_rd_i, fifo_empty_i,
      output req_ready_o, fifo_wr_o, fifo_din_o, level_o
   );

   modport master (
      output req_valid_i, req_data_i, req_last_i,
      output fifo_full_i, fifo_rd_i, fifo_empty_i,
      input  req_ready_o, fifo_wr_o, fifo_din_o, level_o
   );

endinterface

// File: rtl/fifo_wr_arbiter_rr_prio_select.sv
// rr_prio_select: combinational rotating-priority pick. Ports: valid_i, ptr_i
// (highest-priority index) -> gnt_o (one-hot or zero), idx_o (binary winner).
module rr_prio_select
   import fifo_arb_pkg::*;
#(
   parameter int NREQ = NREQ_DEF,
   parameter int IDW  = idw(NREQ)
) (
   input  logic [NREQ-1:0] valid_i,
   input  logic [IDW-1:0]  ptr_i,
   output logic [NREQ-1:0] gnt_o,
   output logic [IDW-1:0]  idx_o
);

   int   k;
   logic found;

   always_comb begin
      gnt_o = '0;
      idx_o = '0;
      found = 1'b0;
      k     = 0;
      for (int i = 0; i < NREQ; i++) begin
         k = (int'(ptr_i) + i) % NREQ;
         if (!found && valid_i[k]) begin
            found    = 1'b1;
            gnt_o[k] = 1'b1;
            idx_o    = IDW'(k);
         end
      end
   end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin share of one FIFO write port, tags each beat
// with its source index and tracks FIFO occupancy (level_o).
// Ports: clk_i, rst_i (async, active-high), bus (fifo_wr_arbiter_if.slave).
// FIFO_ARB_BURST_EN: when defined, a requester keeps the port until req_last.
module fifo_wr_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int NREQ = NREQ_DEF,
   parameter int DW   = DW_DEF,
   parameter int AW   = AW_DEF
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   fifo_wr_arbiter_if.slave        bus
);

   localparam int          IDW     = idw(NREQ);
   localparam logic [AW:0] LVL_MAX = (AW+1)'(1 << AW);

   logic [IDW-1:0]  ptr_q, ptr_d, idx, ptr_inc;
   logic [NREQ-1:0] sel_valid, gnt, ready;
   logic [AW:0]     level_q, level_d;
   logic            wr, rd_ok;

   rr_prio_select #(.NREQ(NREQ), .IDW(IDW)) u_sel (
      .valid_i (sel_valid),
      .ptr_i   (ptr_q),
      .gnt_o   (gnt),
      .idx_o   (idx)
   );

   // Nothing is accepted while full or while held in reset.
   assign ready   = gnt & {NREQ{~bus.fifo_full_i & ~rst_i}};
   assign wr      = |ready;
   assign ptr_inc = (idx == IDW'(NREQ-1)) ? '0 : idx + 1'b1;

   assign bus.req_ready_o = ready;
   assign bus.fifo_wr_o   = wr;
   assign bus.level_o     = level_q;

   always_comb begin
      bus.fifo_din_o = '0;
      if (wr)
         bus.fifo_din_o = {idx, bus.req_data_i[idx*DW +: DW]};
   end

`ifdef FIFO_ARB_BURST_EN
   arb_state_e state_q, state_d;

   // While locked ptr already equals the owner, so mask to ptr.
   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      sel_valid = bus.req_valid_i;
      if (state_q == LOCKED)
         sel_valid = bus.req_valid_i & (NREQ'(1) << ptr_q);
      if (wr) begin
         if (state_q == IDLE) begin
            if (bus.req_last_i[idx]) begin
               ptr_d = ptr_inc;
            end else begin
               state_d = LOCKED;
               ptr_d   = idx;
            end
         end else if (bus.req_last_i[idx]) begin
            state_d = IDLE;
            ptr_d   = ptr_inc;
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) state_q <= IDLE;
      else       state_q <= state_d;
   end
`else
   logic [NREQ-1:0] unused_last;
   assign unused_last = bus.req_last_i;

   always_comb begin
      sel_valid = bus.req_valid_i;
      ptr_d     = wr ? ptr_inc : ptr_q;
   end
`endif

   // Reads of an empty FIFO, or below zero, are not counted.
   assign rd_ok = bus.fifo_rd_i & ~bus.fifo_empty_i & (level_q != '0);

   always_comb begin
      level_d = level_q;
      if (wr && !rd_ok && level_q != LVL_MAX)
         level_d = level_q + 1'b1;
      else if (rd_ok && !wr)
         level_d = level_q - 1'b1;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         ptr_q   <= '0;
         level_q <= '0;
      end else begin
         ptr_q   <= ptr_d;
         level_q <= level_d;
      end
   end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed self-checking bench for fifo_wr_arbiter.
// Expected grants/levels are hand-derived per scenario.
module tb_fifo_wr_arbiter;

   localparam int NREQ  = 4;
   localparam int DW    = 24;
   localparam int AW    = 7;
   localparam int IDW   = 2;
   localparam int DEPTH = 128;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   fifo_wr_arbiter_if #(.NREQ(NREQ), .DW(DW), .AW(AW)) bus ();

   fifo_wr_arbiter #(.NREQ(NREQ), .DW(DW), .AW(AW)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus.slave)
   );

   function automatic logic [DW-1:0] pay(input int k, input int n);
      return {4'hA, 4'(k), 16'(n)};
   endfunction

   function automatic logic [IDW+DW-1:0] word(input int k, input int n);
      return {IDW'(k), pay(k, n)};
   endfunction

   task automatic drive(input logic [NREQ-1:0] v, input int n);
      bus.req_valid_i = v;
      for (int k = 0; k < NREQ; k++)
         bus.req_data_i[k*DW +: DW] = pay(k, n);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   task automatic drain(input int n, input string tag);
      drive('0, 0);
      bus.fifo_rd_i    = 1'b1;
      bus.fifo_empty_i = 1'b0;
      for (int i = 0; i < n; i++) step();
      bus.fifo_rd_i    = 1'b0;
      bus.fifo_empty_i = 1'b1;
      #1;
      checks++;
      if (bus.level_o !== '0) begin
         errors++;
         $display("FAIL %s_drain level got=%0d exp=0", tag, bus.level_o);
      end
   endtask

   task automatic test_reset();
      drive(4'b0000, 0);
      bus.req_last_i   = '0;
      bus.fifo_full_i  = 1'b0;
      bus.fifo_rd_i    = 1'b0;
      bus.fifo_empty_i = 1'b1;
      #1 rst = 1'b1;
      #2;
      checks++;
      if (bus.req_ready_o !== 4'b0000 || bus.fifo_wr_o !== 1'b0) begin
         errors++;
         $display("FAIL reset_ready got=%b/%b exp=0000/0",
                  bus.req_ready_o, bus.fifo_wr_o);
      end
      checks++;
      if (bus.level_o !== '0 || bus.fifo_din_o !== '0) begin
         errors++;
         $display("FAIL reset_level got=%0d din=%h exp=0/0",
                  bus.level_o, bus.fifo_din_o);
      end
      step();
      rst = 1'b0;
      step();
   endtask

   task automatic test_round_robin();
      int e;
      for (int b = 0; b < 8; b++) begin
         drive(4'b1111, b);
         #1;
         e = b % NREQ;
         checks++;
         if (bus.fifo_wr_o !== 1'b1 || bus.fifo_din_o !== word(e, b) ||
             bus.req_ready_o !== 4'(1 << e)) begin
            errors++;
            $display("FAIL rr_beat%0d got=%b/%h exp=%b/%h", b,
                     bus.req_ready_o, bus.fifo_din_o, 4'(1 << e), word(e, b));
         end
         step();
      end
      drive('0, 0);
      #1;
      checks++;
      if (bus.level_o !== 8'd8) begin
         errors++;
         $display("FAIL rr_level got=%0d exp=8", bus.level_o);
      end
      checks++;
      if (bus.fifo_wr_o !== 1'b0 || bus.fifo_din_o !== '0) begin
         errors++;
         $display("FAIL rr_idle got=%b/%h exp=0/0",
                  bus.fifo_wr_o, bus.fifo_din_o);
      end
      drain(8, "rr");
   endtask

   task automatic test_single();
      for (int b = 0; b < 5; b++) begin
         drive(4'b0100, 20 + b);
         #1;
         checks++;
         if (bus.fifo_din_o !== word(2, 20 + b) || bus.fifo_wr_o !== 1'b1) begin
            errors++;
            $display("FAIL single_beat%0d got=%h exp=%h", b,
                     bus.fifo_din_o, word(2, 20 + b));
         end
         step();
      end
      drive(4'b1111, 30);
      #1;
      checks++;
      if (bus.req_ready_o !== 4'b1000) begin
         errors++;
         $display("FAIL single_ptr3 got=%b exp=1000", bus.req_ready_o);
      end
      step();
      drain(6, "single");
   endtask

   task automatic test_full();
      for (int b = 0; b < DEPTH; b++) begin
         drive(4'b0010, b);
         step();
      end
      drive('0, 0);
      #1;
      checks++;
      if (bus.level_o !== 8'd128) begin
         errors++;
         $display("FAIL full_fill got=%0d exp=128", bus.level_o);
      end
      bus.fifo_full_i  = 1'b1;
      bus.fifo_rd_i    = 1'b1;
      bus.fifo_empty_i = 1'b0;
      drive(4'b0010, 200);
      #1;
      checks++;
      if (bus.req_ready_o !== 4'b0000 || bus.fifo_wr_o !== 1'b0) begin
         errors++;
         $display("FAIL full_rd_block got=%b/%b exp=0000/0",
                  bus.req_ready_o, bus.fifo_wr_o);
      end
      step();
      bus.fifo_rd_i = 1'b0;
      #1;
      checks++;
      if (bus.req_ready_o !== 4'b0000 || bus.level_o !== 8'd127) begin
         errors++;
         $display("FAIL full_after_rd got=%b lvl=%0d exp=0000 lvl=127",
                  bus.req_ready_o, bus.level_o);
      end
      bus.fifo_full_i = 1'b0;
      #1;
      checks++;
      if (bus.req_ready_o !== 4'b0010 || bus.fifo_din_o !== word(1, 200)) begin
         errors++;
         $display("FAIL full_release got=%b/%h exp=0010/%h",
                  bus.req_ready_o, bus.fifo_din_o, word(1, 200));
      end
      step();
      bus.fifo_full_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if (bus.level_o !== 8'd128 || bus.fifo_wr_o !== 1'b0) begin
            errors++;
            $display("FAIL full_hold%0d lvl=%0d wr=%b exp lvl=128 wr=0",
                     i, bus.level_o, bus.fifo_wr_o);
         end
      end
      bus.fifo_full_i = 1'b0;
      drain(DEPTH, "full");
      bus.fifo_rd_i    = 1'b1;
      bus.fifo_empty_i = 1'b1;
      step();
      bus.fifo_empty_i = 1'b0;
      step();
      bus.fifo_rd_i = 1'b0;
      bus.fifo_empty_i = 1'b1;
      checks++;
      if (bus.level_o !== '0) begin
         errors++;
         $display("FAIL underflow got=%0d exp=0", bus.level_o);
      end
   endtask

   task automatic test_simul();
      for (int b = 0; b < 10; b++) begin
         drive(4'b0001, b);
         step();
      end
      checks++;
      if (bus.level_o !== 8'd10) begin
         errors++;
         $display("FAIL simul_start got=%0d exp=10", bus.level_o);
      end
      bus.fifo_rd_i    = 1'b1;
      bus.fifo_empty_i = 1'b0;
      for (int c = 0; c < 20; c++) begin
         drive(4'b0001, 50 + c);
         step();
         checks++;
         if (bus.level_o !== 8'd10) begin
            errors++;
            $display("FAIL simul_c%0d got=%0d exp=10", c, bus.level_o);
         end
      end
      drain(10, "simul");
   endtask

   task automatic test_burst();
      int r0;
      int e;
`ifdef FIFO_ARB_BURST_EN
      int exp_seq[6] = '{0, 0, 0, 0, 1, 3};
`else
      int exp_seq[6] = '{0, 1, 3, 0, 1, 3};
`endif
      pulse_reset();
      r0 = 0;
      for (int i = 0; i < 6; i++) begin
         drive({1'b1, 1'b0, 1'b1, r0 < 4}, 100 + i);
         bus.req_last_i = {3'b111, r0 == 3};
         #1;
         e = exp_seq[i];
         checks++;
         if (bus.req_ready_o !== 4'(1 << e) ||
             bus.fifo_din_o !== word(e, 100 + i)) begin
            errors++;
            $display("FAIL burst_beat%0d got=%b/%h exp=%b/%h", i,
                     bus.req_ready_o, bus.fifo_din_o, 4'(1 << e),
                     word(e, 100 + i));
         end
         if (e == 0) r0++;
         step();
      end
      bus.req_last_i = '0;
      drive('0, 0);
   endtask

   task automatic test_reset_mid();
      pulse_reset();
      bus.req_last_i = '0;
      drive(4'b0100, 0);
      step();
      step();
      drive(4'b1111, 1);
      #1;
      checks++;
`ifdef FIFO_ARB_BURST_EN
      if (bus.req_ready_o !== 4'b0100) begin
         errors++;
         $display("FAIL mid_locked got=%b exp=0100", bus.req_ready_o);
      end
`else
      if (bus.req_ready_o !== 4'b1000) begin
         errors++;
         $display("FAIL mid_locked got=%b exp=1000", bus.req_ready_o);
      end
`endif
      rst = 1'b1;
      #1;
      checks++;
      if (bus.req_ready_o !== 4'b0000 || bus.fifo_wr_o !== 1'b0 ||
          bus.fifo_din_o !== '0) begin
         errors++;
         $display("FAIL mid_rst_out got=%b/%b/%h exp=0000/0/0",
                  bus.req_ready_o, bus.fifo_wr_o, bus.fifo_din_o);
      end
      checks++;
      if (bus.level_o !== '0) begin
         errors++;
         $display("FAIL mid_rst_level got=%0d exp=0", bus.level_o);
      end
      step();
      rst = 1'b0;
      #1;
      checks++;
      if (bus.req_ready_o !== 4'b0001 || bus.fifo_din_o !== word(0, 1)) begin
         errors++;
         $display("FAIL mid_restart got=%b/%h exp=0001/%h",
                  bus.req_ready_o, bus.fifo_din_o, word(0, 1));
      end
      step();
      drive('0, 0);
   endtask

   initial begin
      test_reset();
      test_round_robin();
      test_single();
      test_full();
      test_simul();
      test_burst();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
